// File: rtl/icache_pkg.sv
// Shared constants, state encoding and address helpers for the I-cache fill controller.
// The optional ICACHE_CRITICAL_WORD_FIRST_EN build changes only the fill word order.
package icache_pkg;

    localparam int ADDR_W        = 16;
    localparam int INDEX_W       = 6;
    localparam int OFFSET_W      = 4;
    localparam int TAG_W         = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WORD_W        = 3;
    localparam int WORDS_PER_BLK = 8;
    localparam int DATA_W        = 16;
    localparam int MEM_LAT       = 4;

    localparam int TAG_LSB   = INDEX_W + OFFSET_W;
    localparam int INDEX_LSB = OFFSET_W;
    localparam int WORD_LSB  = 1;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_COMMIT = 2'd2
    } fill_state_t;

    function automatic logic [ADDR_W-1:0] blk_addr(
        input logic [TAG_W-1:0]   tag,
        input logic [INDEX_W-1:0] index,
        input logic [WORD_W-1:0]  word
    );
        return {tag, index, word, 1'b0};
    endfunction

endpackage

// File: rtl/icache_tag_array.sv
// 64-entry valid+tag store: combinational read, synchronous write,
// valid bits cleared asynchronously on reset (tags are left as don't-care).
module icache_tag_array
    import icache_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag
);

    localparam int SETS = 1 << INDEX_W;

    logic [SETS-1:0]  valid_reg;
    logic [TAG_W-1:0] tag_mem [SETS];

    generate
        for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[gi] <= 1'b0;
                end else if (wr_en && (wr_index == INDEX_W'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    assign rd_valid = valid_reg[rd_index];
    assign rd_tag   = tag_mem[rd_index];

endmodule

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped I-cache tag lookup and 8-word block miss/fill controller.
// Define ICACHE_CRITICAL_WORD_FIRST_EN to fetch the requested word first (wrapping fill).
module icache_fill_ctrl
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              hit,
    output logic              req_ready,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              da_we,
    output logic [INDEX_W-1:0] da_index,
    output logic [WORD_W-1:0] da_word,
    output logic [DATA_W-1:0] da_wdata,
    output logic              busy
);

    fill_state_t        state_reg;
    logic [TAG_W-1:0]   ltag_reg;
    logic [INDEX_W-1:0] lindex_reg;
    logic [WORD_W-1:0]  lword_reg;
    logic [CNT_W-1:0]   iss_reg;
    logic [CNT_W-1:0]   rcv_reg;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [WORD_W-1:0]  req_word;
    logic               tag_valid;
    logic [TAG_W-1:0]   tag_rd;
    logic [WORD_W-1:0]  iss_word;
    logic [WORD_W-1:0]  rcv_word;
    logic               unused_addr_b0;

    assign req_tag        = req_addr[ADDR_W-1:TAG_LSB];
    assign req_index      = req_addr[TAG_LSB-1:INDEX_LSB];
    assign req_word       = req_addr[INDEX_LSB-1:WORD_LSB];
    assign unused_addr_b0 = req_addr[0];

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    // 3-bit adds wrap naturally past word 7 back to word 0.
    assign iss_word = lword_reg + iss_reg[WORD_W-1:0];
    assign rcv_word = lword_reg + rcv_reg[WORD_W-1:0];
`else
    logic [WORD_W-1:0] unused_lword;
    assign unused_lword = lword_reg;
    assign iss_word     = iss_reg[WORD_W-1:0];
    assign rcv_word     = rcv_reg[WORD_W-1:0];
`endif

    icache_tag_array u_tag_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_index (req_index),
        .rd_valid (tag_valid),
        .rd_tag   (tag_rd),
        .wr_en    (state_reg == ST_COMMIT),
        .wr_index (lindex_reg),
        .wr_tag   (ltag_reg)
    );

    assign hit       = tag_valid && (tag_rd == req_tag);
    assign req_ready = (state_reg == ST_IDLE) && (!req_valid || hit);
    assign busy      = (state_reg != ST_IDLE);

    // Issue and receive are independent; both counters saturate at 8.
    assign mem_en   = (state_reg == ST_FILL) && (iss_reg < CNT_W'(WORDS_PER_BLK));
    assign mem_addr = mem_en ? blk_addr(ltag_reg, lindex_reg, iss_word) : '0;

    assign da_we    = (state_reg == ST_FILL) && mem_data_valid
                      && (rcv_reg < CNT_W'(WORDS_PER_BLK));
    assign da_index = da_we ? lindex_reg  : '0;
    assign da_word  = da_we ? rcv_word    : '0;
    assign da_wdata = da_we ? mem_data_in : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            ltag_reg   <= '0;
            lindex_reg <= '0;
            lword_reg  <= '0;
            iss_reg    <= '0;
            rcv_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid && !hit) begin
                        ltag_reg   <= req_tag;
                        lindex_reg <= req_index;
                        lword_reg  <= req_word;
                        iss_reg    <= '0;
                        rcv_reg    <= '0;
                        state_reg  <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (mem_en) begin
                        iss_reg <= iss_reg + CNT_W'(1);
                    end
                    if (da_we) begin
                        rcv_reg <= rcv_reg + CNT_W'(1);
                        if (rcv_reg == CNT_W'(WORDS_PER_BLK - 1)) begin
                            state_reg <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl with a 4-cycle pipelined memory model.
// Word-order expectations follow ICACHE_CRITICAL_WORD_FIRST_EN when it is defined.
module tb_icache_fill_ctrl;
    import icache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        hit;
    logic        req_ready;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data_in;
    logic        da_we;
    logic [5:0]  da_index;
    logic [2:0]  da_word;
    logic [15:0] da_wdata;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Memory model: a read issued in cycle t returns in cycle t+3.
    logic [2:0]  pv;
    logic [15:0] pa0, pa1, pa2;
    logic        force_v = 1'b0;
    logic [15:0] force_d = 16'h0000;

    always #5 clk = ~clk;

    icache_fill_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .hit            (hit),
        .req_ready      (req_ready),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data_in    (mem_data_in),
        .da_we          (da_we),
        .da_index       (da_index),
        .da_word        (da_word),
        .da_wdata       (da_wdata),
        .busy           (busy)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    function automatic logic [2:0] exp_word(input logic [2:0] lw, input int j);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        return lw + 3'(j);
`else
        return (lw & 3'd0) | 3'(j);
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv  <= 3'b000;
            pa0 <= 16'h0;
            pa1 <= 16'h0;
            pa2 <= 16'h0;
        end else begin
            pv  <= {pv[1:0], mem_en};
            pa0 <= mem_addr;
            pa1 <= pa0;
            pa2 <= pa1;
        end
    end

    assign mem_data_valid = pv[2] | force_v;
    assign mem_data_in    = pv[2] ? mem_word(pa2) : force_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge with the cache idle; returns at cycle 13 (+1).
    task automatic run_fill(input logic [15:0] a);
        logic [5:0] lt;
        logic [5:0] li;
        logic [2:0] lw;
        int n_iss;
        int n_wr;
        lt = a[15:10];
        li = a[9:4];
        lw = a[3:1];
        n_iss = 0;
        n_wr  = 0;
        req_valid = 1'b1;
        req_addr  = a;
        #1;
        chk("miss_hit", hit, 0);
        chk("miss_ready", req_ready, 0);
        chk("miss_busy", busy, 0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 2) req_addr = a ^ 16'hFC00;
            #1;
            chk($sformatf("fill_busy_c%0d", k), busy, 1);
            chk($sformatf("fill_ready_c%0d", k), req_ready, 0);
            chk($sformatf("fill_mem_en_c%0d", k), mem_en, (k <= 8) ? 1 : 0);
            if (mem_en) begin
                chk($sformatf("iss_addr_%0d", n_iss), mem_addr,
                    {lt, li, exp_word(lw, n_iss), 1'b0});
                n_iss++;
            end
            if (da_we) begin
                chk($sformatf("da_index_%0d", n_wr), da_index, li);
                chk($sformatf("da_word_%0d", n_wr), da_word, exp_word(lw, n_wr));
                chk($sformatf("da_wdata_%0d", n_wr), da_wdata,
                    mem_word({lt, li, exp_word(lw, n_wr), 1'b0}));
                n_wr++;
            end
        end
        @(negedge clk);
        req_addr = a;
        #1;
        chk("c13_hit", hit, 1);
        chk("c13_ready", req_ready, 1);
        chk("c13_busy", busy, 0);
        chk("issue_count", n_iss, 8);
        chk("write_count", n_wr, 8);
        $display("fill addr=%h issues=%0d writes=%0d hit=%0d", a, n_iss, n_wr, hit);
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 16'h0000;
        #2 rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_da_we", da_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_da_index", da_index, 0);
        chk("rst_da_word", da_word, 0);
        chk("rst_da_wdata", da_wdata, 0);
        chk("rst_hit", hit, 0);
        chk("rst_ready", req_ready, 1);
        $display("reset busy=%0d mem_en=%0d da_we=%0d", busy, mem_en, da_we);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold miss at 0x0000
        run_fill(16'h0000);

        // Warm hit to another word of the same block
        @(negedge clk);
        req_addr = 16'h0006;
        #1;
        chk("warm_hit", hit, 1);
        chk("warm_ready", req_ready, 1);
        chk("warm_mem_en", mem_en, 0);
        @(negedge clk);
        #1;
        chk("warm_mem_en_next", mem_en, 0);
        chk("warm_busy_next", busy, 0);
        $display("warm hit addr=%h hit=%0d ready=%0d", req_addr, hit, req_ready);

        // Conflict eviction: same index, different tag
        @(negedge clk);
        run_fill(16'h0400);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 16'h0000;
        #1;
        chk("evicted_hit", hit, 0);
        chk("evicted_ready", req_ready, 1);
        req_addr = 16'h0400;
        #1;
        chk("new_tag_hit", hit, 1);
        $display("eviction old_hit=0 new_hit=%0d", hit);

        // Spurious memory return while idle
        force_v = 1'b1;
        force_d = 16'hBEEF;
        #1;
        chk("spur_da_we", da_we, 0);
        chk("spur_busy", busy, 0);
        @(negedge clk);
        force_v = 1'b0;
        #1;
        chk("spur_busy_next", busy, 0);
        chk("spur_mem_en_next", mem_en, 0);
        chk("spur_hit_kept", hit, 1);
        $display("spurious return da_we=%0d busy=%0d", da_we, busy);

        // Miss at a mid-block word (wrapping order when critical-word-first is built)
        @(negedge clk);
        run_fill(16'h002A);

        // Reset after the third data return aborts the fill
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 16'h0000;
        #1;
        chk("pre_rst_miss", hit, 0);
        repeat (6) @(negedge clk);
        #1;
        chk("pre_rst_da_we", da_we, 1);
        chk("pre_rst_mem_en", mem_en, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_mem_en", mem_en, 0);
        chk("midrst_da_we", da_we, 0);
        req_addr = 16'h0400;
        #1;
        chk("midrst_valid_clear", hit, 0);
        $display("mid-fill reset busy=%0d mem_en=%0d da_we=%0d", busy, mem_en, da_we);
        @(negedge clk);
        rst_n = 1'b1;
        run_fill(16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
